// File: rtl/turn_pt_marker_gen.sv
// ============================================================================
// Module   : turn_pt_marker_gen
// Purpose  : Per-turn / per-PT-cycle marker generator with EVR resync.
//            Optional macro TURN_PT_MARKER_FREERUN_EN: run from reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_pt_marker_gen #(
    parameter int SAMPLES_WIDTH = 8,
    parameter int TURNS_WIDTH   = 6,
    parameter int ERRCNT_WIDTH  = 16
) (
    input  logic                     adcClk,
    input  logic                     adcReset,
    input  logic [SAMPLES_WIDTH-1:0] samplesPerTurn,
    input  logic [TURNS_WIDTH-1:0]   turnsPerPT,
    input  logic [SAMPLES_WIDTH-1:0] turnOffset,
    input  logic                     evrFiducial,
    output logic                     turnMarker,
    output logic                     ptMarker,
    output logic [SAMPLES_WIDTH-1:0] sampleIndex,
    output logic [TURNS_WIDTH-1:0]   turnIndex,
    output logic                     synced,
    output logic                     configError,
    output logic                     resyncError,
    output logic [ERRCNT_WIDTH-1:0]  resyncErrorCount
);

    localparam logic [0:0] S_UNSYNCED = 1'b0;
    localparam logic [0:0] S_RUNNING  = 1'b1;

    localparam logic [SAMPLES_WIDTH-1:0] c_s_one = SAMPLES_WIDTH'(1);
    localparam logic [SAMPLES_WIDTH-1:0] c_s_two = SAMPLES_WIDTH'(2);
    localparam logic [TURNS_WIDTH-1:0]   c_t_one = TURNS_WIDTH'(1);

    logic [0:0]               r_state;
    logic [SAMPLES_WIDTH-1:0] r_spt;
    logic [TURNS_WIDTH-1:0]   r_tpp;
    logic [SAMPLES_WIDTH-1:0] r_off;
    logic [SAMPLES_WIDTH-1:0] r_sidx;
    logic [TURNS_WIDTH-1:0]   r_tidx;
    logic                     r_turn;
    logic                     r_pt;
    logic                     r_rerr;
    logic [ERRCNT_WIDTH-1:0]  r_ecnt;

    logic [0:0]               w_state_nxt;
    logic [SAMPLES_WIDTH-1:0] w_sidx_nxt;
    logic [TURNS_WIDTH-1:0]   w_tidx_nxt;
    logic                     w_load;
    logic                     w_rerr_nxt;
    logic                     w_in_valid;
    logic                     w_sh_valid;
    logic [SAMPLES_WIDTH-1:0] w_eff_off;
    logic                     w_sidx_last;
    logic                     w_tidx_last;
    logic                     w_turn_nxt;
    logic [0:0]               w_reset_state;

    assign w_in_valid  = (samplesPerTurn >= c_s_two) && (turnsPerPT != '0);
    assign w_sh_valid  = (r_spt >= c_s_two) && (r_tpp != '0);
    assign w_eff_off   = (r_off >= r_spt) ? '0 : r_off;
    assign w_sidx_last = (r_sidx == r_spt - c_s_one);
    assign w_tidx_last = (r_tidx == r_tpp - c_t_one);
    assign w_turn_nxt  = (r_state == S_RUNNING) && (r_sidx == w_eff_off);

`ifdef TURN_PT_MARKER_FREERUN_EN
    assign w_reset_state = w_in_valid ? S_RUNNING : S_UNSYNCED;
`else
    assign w_reset_state = S_UNSYNCED;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sidx_nxt  = r_sidx;
        w_tidx_nxt  = r_tidx;
        w_load      = 1'b0;
        w_rerr_nxt  = 1'b0;
        case (r_state)
            S_UNSYNCED: begin
                // Shadow tracks the inputs so configError is live while waiting
                w_load     = 1'b1;
                w_sidx_nxt = '0;
                w_tidx_nxt = '0;
                if (evrFiducial && w_in_valid) begin
                    w_state_nxt = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (evrFiducial) begin
                    w_load     = 1'b1;
                    w_sidx_nxt = '0;
                    w_tidx_nxt = '0;
                    if (!w_in_valid) begin
                        w_state_nxt = S_UNSYNCED;
                    end else if (!(w_sidx_last && w_tidx_last)) begin
                        w_rerr_nxt = 1'b1;
                    end
                end else if (w_sidx_last) begin
                    w_sidx_nxt = '0;
                    w_tidx_nxt = w_tidx_last ? '0 : r_tidx + c_t_one;
                end else begin
                    w_sidx_nxt = r_sidx + c_s_one;
                end
            end
            default: begin
                w_state_nxt = S_UNSYNCED;
                w_sidx_nxt  = '0;
                w_tidx_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            r_state <= w_reset_state;
            r_spt   <= samplesPerTurn;
            r_tpp   <= turnsPerPT;
            r_off   <= turnOffset;
            r_sidx  <= '0;
            r_tidx  <= '0;
            r_turn  <= 1'b0;
            r_pt    <= 1'b0;
            r_rerr  <= 1'b0;
            r_ecnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_spt <= samplesPerTurn;
                r_tpp <= turnsPerPT;
                r_off <= turnOffset;
            end
            r_sidx <= w_sidx_nxt;
            r_tidx <= w_tidx_nxt;
            r_turn <= w_turn_nxt;
            r_pt   <= w_turn_nxt && (r_tidx == '0);
            r_rerr <= w_rerr_nxt;
            if (w_rerr_nxt && (r_ecnt != '1)) begin
                r_ecnt <= r_ecnt + ERRCNT_WIDTH'(1);
            end
        end
    end

    assign turnMarker       = r_turn;
    assign ptMarker         = r_pt;
    assign sampleIndex      = r_sidx;
    assign turnIndex        = r_tidx;
    assign synced           = (r_state == S_RUNNING);
    assign configError      = !w_sh_valid;
    assign resyncError      = r_rerr;
    assign resyncErrorCount = r_ecnt;

endmodule

`default_nettype wire
